sha_1_padder: RTL and testbench

Message-side front end for `sha_1_core`. It accepts an arbitrary-length byte stream and performs FIPS 180-4 SHA-1 padding: a 0x80 marker, zero fill, and a 64-bit big-endian bit length. It packs the result into 16×32-bit big-endian 512-bit blocks and presents them on a valid/ready block interface that drives the core's `data` array. It is the writer of the core's block input and sits between the byte source and the hash engine or chaining logic.

---
 rtl/sha_1_padder.sv | 199 +++++++++++++++++++
 tb/tb_sha_1_padder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_1_padder.sv
// sha_1_padder: byte-stream front end for a SHA-1 core.
// Takes a message one byte per cycle, appends the 0x80 marker, zero fill and
// the 64-bit big-endian bit length, and presents 512-bit blocks of sixteen
// big-endian words on a valid/ready interface.
//
// Handshakes: a byte moves when in_valid & in_ready are both high on a rising
// edge; a block moves when q_valid & block_ready are both high on a rising
// edge. While a side's valid is high and ready is low, that side holds its
// payload stable.
module sha_1_padder #(
  parameter int COUNT_W = 61
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        in_empty,
  output logic        in_ready,
  output logic [31:0] q_block [16],
  output logic        q_valid,
  output logic        q_first,
  output logic        q_last,
  input  logic        block_ready,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    LEN  = 2'd2,
    EMIT = 2'd3
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         buffer [64];
  logic [5:0]         idx;
  logic [5:0]         pad_pos;
  logic [COUNT_W-1:0] cnt;
  logic               first_pend;
  logic               pad_pend;
  logic               len_pend;
  logic [COUNT_W+2:0] bit_cnt;
  logic [63:0]        len64;

  // Bit length wraps with the byte counter and is fitted to 64 bits.
  assign bit_cnt   = {cnt, 3'b000};
  assign len64     = 64'(bit_cnt);

  assign in_ready  = (state == FILL);
  assign q_valid   = (state == EMIT);
  assign fsm_state = state;

  // Pack the byte buffer into big-endian words: byte 4w lands in bits 31:24.
  always_comb begin
    for (int w = 0; w < 16; w++) begin
      q_block[w] = {buffer[4*w], buffer[4*w+1], buffer[4*w+2], buffer[4*w+3]};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL: begin
        if (in_valid) begin
          if (in_last && in_empty) begin
            state_nxt = PAD;
          end else if (idx == 6'd63) begin
            state_nxt = EMIT;
          end else if (in_last) begin
            state_nxt = PAD;
          end
        end
      end
      PAD:  state_nxt = EMIT;
      LEN:  state_nxt = EMIT;
      EMIT: begin
        if (block_ready) begin
          if (pad_pend) begin
            state_nxt = PAD;
          end else if (len_pend) begin
            state_nxt = LEN;
          end else begin
            state_nxt = FILL;
          end
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Datapath: buffer writes, counters, pending flags and block tags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 64; i++) begin
        buffer[i] <= 8'h00;
      end
      idx        <= 6'd0;
      pad_pos    <= 6'd0;
      cnt        <= '0;
      first_pend <= 1'b1;
      pad_pend   <= 1'b0;
      len_pend   <= 1'b0;
      q_first    <= 1'b0;
      q_last     <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            if (in_last && in_empty) begin
              // Zero-length terminator: nothing stored, marker goes at idx.
              pad_pos <= idx;
            end else begin
              buffer[idx] <= in_data;
              idx         <= idx + 6'd1;
              cnt         <= cnt + CNT_ONE;
              if (idx == 6'd63) begin
                // Block full: emit it as a data-only block.
                q_first    <= first_pend;
                first_pend <= 1'b0;
                q_last     <= 1'b0;
                if (in_last) begin
                  pad_pend <= 1'b1;
                  pad_pos  <= 6'd0;
                end
              end else if (in_last) begin
                pad_pos <= idx + 6'd1;
              end
            end
          end
        end
        PAD: begin
          for (int i = 0; i < 64; i++) begin
            if (6'(i) == pad_pos) begin
              buffer[i] <= 8'h80;
            end else if (6'(i) > pad_pos) begin
              buffer[i] <= 8'h00;
            end
          end
          if (pad_pos <= 6'd55) begin
            // Room for the length field in this block.
            for (int k = 0; k < 8; k++) begin
              buffer[56+k] <= len64[63-8*k -: 8];
            end
            q_last <= 1'b1;
          end else begin
            len_pend <= 1'b1;
            q_last   <= 1'b0;
          end
          q_first    <= first_pend;
          first_pend <= 1'b0;
          pad_pend   <= 1'b0;
        end
        LEN: begin
          for (int i = 0; i < 56; i++) begin
            buffer[i] <= 8'h00;
          end
          for (int k = 0; k < 8; k++) begin
            buffer[56+k] <= len64[63-8*k -: 8];
          end
          q_first    <= first_pend;
          first_pend <= 1'b0;
          q_last     <= 1'b1;
          len_pend   <= 1'b0;
        end
        EMIT: begin
          if (block_ready) begin
            for (int i = 0; i < 64; i++) begin
              buffer[i] <= 8'h00;
            end
            idx     <= 6'd0;
            q_first <= 1'b0;
            q_last  <= 1'b0;
            if (q_last) begin
              // Message complete: next block starts a fresh message.
              cnt        <= '0;
              first_pend <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha_1_padder.sv
// Testbench for sha_1_padder: directed test-plan messages plus random
// messages, checked by a scoreboard fed from a byte-level padding model.
module tb_sha_1_padder;

  localparam int W = 514;  // {first, last, 512-bit block}

  logic        clk;
  logic        reset_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_empty;
  logic        in_ready;
  logic [31:0] q_block [16];
  logic        q_valid;
  logic        q_first;
  logic        q_last;
  logic        block_ready;
  logic [1:0]  fsm_state;

  logic [W-1:0] exp_q[$];
  int checks;
  int errors;
  bit hold;

  sha_1_padder #(.COUNT_W(61)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_last(in_last),
    .in_empty(in_empty),
    .in_ready(in_ready),
    .q_block(q_block),
    .q_valid(q_valid),
    .q_first(q_first),
    .q_last(q_last),
    .block_ready(block_ready),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Consumer: random backpressure unless held off.
  initial begin
    block_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      block_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  // Reference model: padded byte stream split into 64-byte blocks.
  task automatic model_push(input logic [7:0] m[$]);
    logic [7:0]   pad[$];
    logic [63:0]  bitlen;
    logic [511:0] blk;
    int nblk;
    pad = m;
    pad.push_back(8'h80);
    while (pad.size() % 64 != 56) pad.push_back(8'h00);
    bitlen = 64'(m.size()) * 64'd8;
    for (int k = 0; k < 8; k++) pad.push_back(bitlen[63-8*k -: 8]);
    nblk = pad.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pad[64*b+j];
      exp_q.push_back({(b == 0), (b == nblk - 1), blk});
    end
  endtask

  // Driver: present one beat, wait (bounded) for acceptance.
  task automatic put_beat(input logic [7:0] d, input logic last, input logic empty);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_empty = empty;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got=0 required=1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] m[$], input bit empty_term, input bit bubbles);
    model_push(m);
    for (int i = 0; i < m.size(); i++) begin
      put_beat(m[i], (!empty_term && i == m.size() - 1), 1'b0);
      if (bubbles && $urandom_range(0, 5) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    if (empty_term) put_beat($urandom_range(0, 255), 1'b1, 1'b1);
  endtask

  // Scoreboard monitor: compare each block at its handshake.
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] req;
    if (reset_n && q_valid && block_ready) begin
      for (int w = 0; w < 16; w++) got[511-32*w -: 32] = q_block[w];
      got[513] = q_first;
      got[512] = q_last;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_block got=%0h required=none", got);
      end else begin
        req = exp_q.pop_front();
        if (got !== req) begin
          errors++;
          $display("FAIL block got=%0h required=%0h", got, req);
        end
      end
    end
  end

  initial begin
    logic [7:0] m[$];
    logic [31:0] orw;
    bit et;
    int len;
    int n;
    checks = 0;
    errors = 0;
    hold = 1'b0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    in_empty = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    orw = 32'h0;
    for (int w = 0; w < 16; w++) orw |= q_block[w];
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_q_valid", 64'(q_valid), 64'd0);
    check("rst_q_first", 64'(q_first), 64'd0);
    check("rst_q_last", 64'(q_last), 64'd0);
    check("rst_q_block", 64'(orw), 64'd0);
    @(posedge clk);
    #1;

    // "abc" under backpressure, latency, stability, then reset mid-EMIT.
    hold = 1'b1;
    #2;
    put_beat(8'h61, 1'b0, 1'b0);
    put_beat(8'h62, 1'b0, 1'b0);
    put_beat(8'h63, 1'b1, 1'b0);
    check("abc_lat_pad", 64'(q_valid), 64'd0);
    @(posedge clk);
    #1;
    check("abc_lat_emit", 64'(q_valid), 64'd1);
    for (int c = 0; c < 10; c++) begin
      check("hold_q_valid", 64'(q_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_w0", 64'(q_block[0]), 64'h61626380);
      check("hold_w15", 64'(q_block[15]), 64'h18);
      check("hold_tags", 64'({q_first, q_last}), 64'd3);
      @(posedge clk);
      #1;
    end
    reset_n = 1'b0;
    #1;
    check("rst_mid_q_valid", 64'(q_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    hold = 1'b0;
    @(posedge clk);
    #1;

    // Directed test-plan messages.
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 1'b0, 1'b0);
    m.delete();
    send_msg(m, 1'b1, 1'b0);
    for (int i = 0; i < 55; i++) m.push_back(8'h41);
    send_msg(m, 1'b0, 1'b0);
    m.push_back(8'h41);
    send_msg(m, 1'b0, 1'b0);
    m.delete();
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom_range(0, 255)));
    send_msg(m, 1'b0, 1'b0);
    m.delete();
    for (int i = 0; i < 64; i++) m.push_back(8'($urandom_range(0, 255)));
    send_msg(m, 1'b1, 1'b0);

    // Random messages.
    for (int r = 0; r < 25; r++) begin
      m.delete();
      len = $urandom_range(0, 140);
      for (int i = 0; i < len; i++) m.push_back(8'($urandom_range(0, 255)));
      et = (len == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      send_msg(m, et, 1'b1);
    end

    // Drain the scoreboard (bounded).
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      n++;
      @(posedge clk);
    end
    repeat (4) @(posedge clk);
    check("drain_left", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
